// File: rtl/psum_acc_bank_pkg.sv
// Shared types, limits and the saturating lane adder for the partial-sum bank.
package psum_acc_bank_pkg;

   localparam int PSUM_BW  = 16;
   localparam int COL      = 8;
   localparam int LEN_ONIJ = 16;
   localparam int ADDR_W   = $clog2(LEN_ONIJ);

   localparam logic [PSUM_BW-1:0] PSUM_MAX = {1'b0, {(PSUM_BW-1){1'b1}}};
   localparam logic [PSUM_BW-1:0] PSUM_MIN = {1'b1, {(PSUM_BW-1){1'b0}}};

   typedef enum logic {
      ACC_OVERWRITE = 1'b0,
      ACC_ACCUM     = 1'b1
   } acc_mode_e;

   typedef struct packed {
      logic [PSUM_BW-1:0] sum;
      logic               ovf;
   } sat_res_t;

   // Signed add at PSUM_BW+1 bits; overflow when the two top bits disagree.
   function automatic sat_res_t sat_add(input logic [PSUM_BW-1:0] a,
                                        input logic [PSUM_BW-1:0] b);
      logic [PSUM_BW:0] wide;
      sat_res_t         r;
      wide  = {a[PSUM_BW-1], a} + {b[PSUM_BW-1], b};
      r.ovf = wide[PSUM_BW] ^ wide[PSUM_BW-1];
      if (r.ovf) r.sum = wide[PSUM_BW] ? PSUM_MIN : PSUM_MAX;
      else       r.sum = wide[PSUM_BW-1:0];
      return r;
   endfunction

endpackage

// File: rtl/psum_acc_bank_lane_alu.sv
// Single-lane S1 datapath: overwrite, or signed add with optional saturation.
module psum_lane_alu
   import psum_acc_bank_pkg::*;
#(
   parameter int W      = PSUM_BW,
   parameter bit SAT_EN = 1'b1
) (
   input  acc_mode_e    mode_i,
   input  logic [W-1:0] op_i,
   input  logic [W-1:0] data_i,
   output logic [W-1:0] res_o,
   output logic         sat_o
);

   logic [W-1:0] sat_val;
   logic         ovf;

   if (W == PSUM_BW) begin : g_pkg_add
      sat_res_t r;
      assign r       = sat_add(op_i, data_i);
      assign sat_val = r.sum;
      assign ovf     = r.ovf;
   end else begin : g_gen_add
      logic [W:0] wide;
      assign wide    = {op_i[W-1], op_i} + {data_i[W-1], data_i};
      assign ovf     = wide[W] ^ wide[W-1];
      assign sat_val = !ovf    ? wide[W-1:0] :
                       wide[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}};
   end

   always_comb begin
      res_o = data_i;
      sat_o = 1'b0;
      if (mode_i == ACC_ACCUM) begin
         if (SAT_EN) begin
            res_o = sat_val;
            sat_o = ovf;
         end else begin
            res_o = op_i + data_i;
         end
      end
   end

endmodule

// File: rtl/psum_acc_bank.sv
// Partial-sum bank: 2-stage overwrite/accumulate write path with forwarding,
// hardware clear sweep, and an independent 1-cycle read port with ReLU.
module psum_acc_bank
   import psum_acc_bank_pkg::*;
#(
   parameter int psum_bw  = PSUM_BW,
   parameter int col      = COL,
   parameter int len_onij = LEN_ONIJ,
   parameter bit SAT_EN   = 1'b1
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        acc_valid_i,
   output logic                        acc_ready_o,
   input  logic                        acc_mode_i,
   input  logic [$clog2(len_onij)-1:0] acc_addr_i,
   input  logic [psum_bw*col-1:0]      acc_data_i,
   input  logic                        clear_i,
   output logic                        clear_busy_o,
   input  logic                        rd_en_i,
   input  logic [$clog2(len_onij)-1:0] rd_addr_i,
   input  logic                        relu_en_i,
   output logic [psum_bw*col-1:0]      rd_data_o,
   output logic                        rd_valid_o,
   output logic                        sat_flag_o,
   output logic                        idle_o
);

   localparam int            AW    = $clog2(len_onij);
   localparam int            WW    = psum_bw * col;
   localparam logic [AW:0]   DEPTH = (AW+1)'(len_onij);
   localparam logic [AW-1:0] LAST  = AW'(len_onij - 1);

   logic [WW-1:0] mem_q [len_onij];

   logic          s1_valid_q;
   acc_mode_e     s1_mode_q;
   logic [AW-1:0] s1_addr_q;
   logic [WW-1:0] s1_data_q, s1_op_q, s1_res;
   logic [col-1:0] lane_sat;

   logic          clr_busy_q, clr_pend_q, sat_q, rd_valid_q;
   logic [AW-1:0] clr_addr_q;
   logic [WW-1:0] rd_data_q, rd_data_d, op_d, rd_word;

   logic accept, clr_start, acc_in_range, s1_in_range, rd_in_range;

   assign accept       = acc_valid_i & ~clr_busy_q;
   assign acc_in_range = {1'b0, acc_addr_i} < DEPTH;
   assign s1_in_range  = {1'b0, s1_addr_q} < DEPTH;
   assign rd_in_range  = {1'b0, rd_addr_i} < DEPTH;

   // A clear seen while S1 is occupied waits exactly one cycle for that write.
   assign clr_start = ~clr_busy_q & ((clear_i & ~s1_valid_q) | clr_pend_q);

   assign op_d = (s1_valid_q && (s1_addr_q == acc_addr_i)) ? s1_res
               : acc_in_range ? mem_q[acc_addr_i] : '0;

   for (genvar k = 0; k < col; k++) begin : g_lane
      psum_lane_alu #(
         .W      (psum_bw),
         .SAT_EN (SAT_EN)
      ) u_alu (
         .mode_i (s1_mode_q),
         .op_i   (s1_op_q[k*psum_bw +: psum_bw]),
         .data_i (s1_data_q[k*psum_bw +: psum_bw]),
         .res_o  (s1_res[k*psum_bw +: psum_bw]),
         .sat_o  (lane_sat[k])
      );
   end

   always_comb begin
      rd_word   = rd_in_range ? mem_q[rd_addr_i] : '0;
      rd_data_d = rd_word;
      for (int k = 0; k < col; k++) begin
         if (relu_en_i && rd_word[k*psum_bw + psum_bw - 1]) rd_data_d[k*psum_bw +: psum_bw] = '0;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1_valid_q <= 1'b0;
         s1_mode_q  <= ACC_OVERWRITE;
         s1_addr_q  <= '0;
         s1_data_q  <= '0;
         s1_op_q    <= '0;
         clr_busy_q <= 1'b0;
         clr_pend_q <= 1'b0;
         clr_addr_q <= '0;
         sat_q      <= 1'b0;
         rd_valid_q <= 1'b0;
         rd_data_q  <= '0;
      end else begin
         s1_valid_q <= accept;
         if (accept) begin
            s1_mode_q <= acc_mode_e'(acc_mode_i);
            s1_addr_q <= acc_addr_i;
            s1_data_q <= acc_data_i;
            s1_op_q   <= op_d;
         end

         clr_pend_q <= ~clr_busy_q & ~clr_pend_q & clear_i & s1_valid_q;
         if (clr_start) begin
            clr_busy_q <= 1'b1;
            clr_addr_q <= '0;
         end else if (clr_busy_q) begin
            if (clr_addr_q == LAST) clr_busy_q <= 1'b0;
            clr_addr_q <= clr_addr_q + 1'b1;
         end

         if (clr_start)                                   sat_q <= 1'b0;
         else if (s1_valid_q && s1_in_range && |lane_sat) sat_q <= 1'b1;

         rd_valid_q <= rd_en_i;
         if (rd_en_i) rd_data_q <= rd_data_d;
      end
   end

   // NOTE: the array has no reset; its contents are defined by the first clear sweep.
   // The sweep write is placed last so it wins when it collides with an S1 write.
   always_ff @(posedge clk) begin
      if (s1_valid_q && s1_in_range) mem_q[s1_addr_q] <= s1_res;
      if (clr_busy_q)                mem_q[clr_addr_q] <= '0;
   end

   assign acc_ready_o  = ~clr_busy_q;
   assign clear_busy_o = clr_busy_q;
   assign rd_data_o    = rd_data_q;
   assign rd_valid_o   = rd_valid_q;
   assign sat_flag_o   = sat_q;
   assign idle_o       = ~s1_valid_q & ~clr_busy_q & ~clr_pend_q;

endmodule
